// File: rtl/psum_issue_scheduler.sv
// Purpose : buffers MAC partial sums in a FIFO and issues them to the output accumulator as start pulses.
// Latency : a word pushed into an empty, idle scheduler gives out_start on the second edge after the push.
// Backpr. : in_ready = !full; downstream has no backpressure, so pulses are spaced >= ISSUE_GAP cycles.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_data (DATA_W), in_addr (ADDR_W)
//   out_start             one-cycle issue pulse; out_data/out_addr valid with it, held between pulses
//   level                 FIFO occupancy ($clog2(DEPTH)+1 bits)
//   busy                  words queued, spacing timer running, or a pulse on the output
// Optional (PSUM_ISSUE_CNT_EN defined):
//   total_cnt [15:0] in   expected word count (0 disables done)
//   issue_cnt [15:0] out  pulses issued since the last done
//   done             out  one-cycle pulse the cycle after the pulse that reaches total_cnt
module psum_issue_scheduler #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [ADDR_W-1:0]       in_addr,
  output logic                    out_start,
  output logic [DATA_W-1:0]       out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy
`ifdef PSUM_ISSUE_CNT_EN
  ,
  input  logic [15:0]             total_cnt,
  output logic [15:0]             issue_cnt,
  output logic                    done
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  // gap_cnt only needs to hold ISSUE_GAP-1
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [GW-1:0]     gap_cnt, gap_nxt;
  logic [LW-1:0]     level_nxt;
  logic              full, push, pop;

  assign full     = (level == LW'(DEPTH));
  assign in_ready = !full;
  // A pop never frees space for a same-cycle push: push depends on full only.
  assign push     = in_valid && !full;
  assign pop      = (level != '0) && (gap_cnt == '0);
  assign busy     = (state == ISSUE) || out_start;

  // Next-state of occupancy/timer, and the FSM that mirrors them.
  always_comb begin
    level_nxt = level;
    gap_nxt   = gap_cnt;
    state_nxt = IDLE;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
    if (pop) begin
      gap_nxt = GW'(ISSUE_GAP - 1);
    end else if (gap_cnt != '0) begin
      gap_nxt = gap_cnt - GW'(1);
    end
    if ((level_nxt != '0) || (gap_nxt != '0)) begin
      state_nxt = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      gap_cnt   <= '0;
      out_start <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      state   <= state_nxt;
      level   <= level_nxt;
      gap_cnt <= gap_nxt;
      // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      out_start <= pop;
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        out_data <= mem_data[rd_ptr];
        out_addr <= mem_addr[rd_ptr];
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

`ifdef PSUM_ISSUE_CNT_EN
  logic cnt_hit;

  // Evaluated during the out_start cycle, when issue_cnt already includes that pulse.
  assign cnt_hit = out_start && (total_cnt != 16'd0) && (issue_cnt == total_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= 16'd0;
      done      <= 1'b0;
    end else begin
      done <= cnt_hit;
      if (cnt_hit) begin
        // With ISSUE_GAP==1 the next pulse can coincide with the clear.
        issue_cnt <= pop ? 16'd1 : 16'd0;
      end else if (pop) begin
        issue_cnt <= issue_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
